// File: rtl/ram_pkg.sv
// Shared definitions for the simple dual-port RAM family.
package ram_pkg;

  // Same-address read-during-write policy encodings.
  localparam int RD_OLD = 0;
  localparam int RD_NEW = 1;

  function automatic int addr_width(input int size);
    return (size > 2) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/sdp_ram_if.sv
// Read/write port bundle for sdp_ram; the caller drives through master.
interface sdp_ram_if #(
  parameter int WIDTH = 25,
  parameter int AW    = 9
);
  logic             rden;
  logic [AW-1:0]    rdaddr;
  logic [WIDTH-1:0] rddata;
  logic             rdvalid;
  logic             wren;
  logic [AW-1:0]    wraddr;
  logic [WIDTH-1:0] wrdata;

  modport master (
    output rden, rdaddr, wren, wraddr, wrdata,
    input  rddata, rdvalid
  );

  modport slave (
    input  rden, rdaddr, wren, wraddr, wrdata,
    output rddata, rdvalid
  );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port block RAM, one clock, with an optional output register.
// Only the read path is reset; array contents survive rst.
module sdp_ram
  import ram_pkg::*;
#(
  parameter int WIDTH   = 25,
  parameter int SIZE    = 512,
  parameter int BYPASS  = RD_OLD,
  parameter int OUT_REG = 0
) (
  input  logic     clk,
  input  logic     rst,
  sdp_ram_if.slave bus
);

  localparam int AW = addr_width(SIZE);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [AW-1:0]    rdaddr;
  logic [AW-1:0]    wraddr;
  logic             rd_in;
  logic             wr_in;
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;
  logic             rdv_q;

  assign rdaddr = bus.rdaddr;
  assign wraddr = bus.wraddr;
  assign rd_in  = 32'(rdaddr) < 32'(SIZE);
  assign wr_in  = 32'(wraddr) < 32'(SIZE);

  // Array has no reset so it maps onto block RAM; writes are gated by rst.
  always_ff @(posedge clk) begin
    if (!rst && bus.wren && wr_in) begin
      mem_q[wraddr] <= bus.wrdata;
    end
  end

  always_comb begin
    rd_d = '0;
    if (rd_in) begin
      if (BYPASS == RD_NEW && bus.wren && wraddr == rdaddr) begin
        rd_d = bus.wrdata;
      end else begin
        rd_d = mem_q[rdaddr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      rdv_q <= 1'b0;
    end else begin
      rdv_q <= bus.rden;
      if (bus.rden) begin
        rd_q <= rd_d;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] out_q;
      logic             outv_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q  <= '0;
          outv_q <= 1'b0;
        end else begin
          outv_q <= rdv_q;
          if (rdv_q) begin
            out_q <= rd_q;
          end
        end
      end

      assign bus.rddata  = out_q;
      assign bus.rdvalid = outv_q;
    end else begin : g_no_out_reg
      assign bus.rddata  = rd_q;
      assign bus.rdvalid = rdv_q;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_ram.sv
// Self-checking bench for sdp_ram across four parameter sets.
module tb_sdp_ram;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // u0: 512 words, read-old; u1: 8 words, read-new; u2: 16 words, output reg; u3: 6 words.
  sdp_ram_if #(.WIDTH(25), .AW(9)) i0 ();
  sdp_ram_if #(.WIDTH(25), .AW(3)) i1 ();
  sdp_ram_if #(.WIDTH(25), .AW(4)) i2 ();
  sdp_ram_if #(.WIDTH(25), .AW(3)) i3 ();

  sdp_ram #(.WIDTH(25), .SIZE(512), .BYPASS(0), .OUT_REG(0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  sdp_ram #(.WIDTH(25), .SIZE(8),   .BYPASS(1), .OUT_REG(0)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  sdp_ram #(.WIDTH(25), .SIZE(16),  .BYPASS(0), .OUT_REG(1)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));
  sdp_ram #(.WIDTH(25), .SIZE(6),   .BYPASS(0), .OUT_REG(0)) u3 (.clk(clk), .rst(rst), .bus(i3.slave));

  // Reference contents, zero at start of simulation.
  logic [24:0] m0 [512];
  logic [24:0] m2 [16];
  logic [24:0] m3 [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    i0.rden = 0; i0.wren = 0; i0.rdaddr = '0; i0.wraddr = '0; i0.wrdata = '0;
    i1.rden = 0; i1.wren = 0; i1.rdaddr = '0; i1.wraddr = '0; i1.wrdata = '0;
    i2.rden = 0; i2.wren = 0; i2.rdaddr = '0; i2.wraddr = '0; i2.wrdata = '0;
    i3.rden = 0; i3.wren = 0; i3.rdaddr = '0; i3.wraddr = '0; i3.wrdata = '0;
  endtask

  initial begin
    logic [24:0] e0, e2, e3, p2d;
    logic        v0, v2, v3, p2v;
    int unsigned a0r, a0w, a2r, a2w, a3r, a3w;
    logic [24:0] d0, d2, d3;

    for (int i = 0; i < 512; i++) m0[i] = '0;
    for (int i = 0; i < 16; i++)  m2[i] = '0;
    for (int i = 0; i < 6; i++)   m3[i] = '0;

    // Power-up reset
    rst = 1'b1;
    idle_all();
    repeat (2) tick();
    chk("rst_u0_data", 32'(i0.rddata), 32'h0);
    chk("rst_u0_valid", 32'(i0.rdvalid), 32'h0);
    chk("rst_u2_valid", 32'(i2.rdvalid), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle_valid", 32'(i0.rdvalid), 32'h0);

    // Basic write then read
    i0.wren = 1; i0.wraddr = 9'd5; i0.wrdata = 25'h0ABCDEF;
    tick();
    m0[5] = 25'h0ABCDEF;
    i0.wren = 0; i0.rden = 1; i0.rdaddr = 9'd5;
    tick();
    chk("basic_data", 32'(i0.rddata), 32'h0ABCDEF);
    chk("basic_valid", 32'(i0.rdvalid), 32'h1);
    i0.rden = 0;
    tick();
    chk("hold_data", 32'(i0.rddata), 32'h0ABCDEF);
    chk("hold_valid", 32'(i0.rdvalid), 32'h0);

    // Asynchronous reset between edges; a write during reset must be dropped
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data", 32'(i0.rddata), 32'h0);
    chk("async_rst_valid", 32'(i0.rdvalid), 32'h0);
    i0.wren = 1; i0.wraddr = 9'd9; i0.wrdata = 25'h77;
    tick();
    i0.wren = 0;
    rst = 1'b0;
    tick();
    chk("rel_rst_valid", 32'(i0.rdvalid), 32'h0);
    i0.rden = 1; i0.rdaddr = 9'd9;
    tick();
    chk("wr_in_rst_dropped", 32'(i0.rddata), 32'(m0[9]));

    // Collision, read-old then read-new
    i0.rden = 0; i0.wren = 1; i0.wraddr = 9'd3; i0.wrdata = 25'h11;
    i1.wren = 1; i1.wraddr = 3'd3; i1.wrdata = 25'h11;
    tick();
    m0[3] = 25'h11;
    i0.rden = 1; i0.rdaddr = 9'd3; i0.wrdata = 25'h22;
    i1.rden = 1; i1.rdaddr = 3'd3; i1.wrdata = 25'h22;
    tick();
    m0[3] = 25'h22;
    chk("coll_old", 32'(i0.rddata), 32'h11);
    chk("coll_new", 32'(i1.rddata), 32'h22);
    i0.wren = 0; i1.wren = 0;
    tick();
    chk("coll_old_after", 32'(i0.rddata), 32'h22);
    chk("coll_new_after", 32'(i1.rddata), 32'h22);
    idle_all();

    // Streaming delay line on the 8-word RAM
    for (int n = 0; n < 40; n++) begin
      i1.wren = 1; i1.rden = 1;
      i1.wraddr = 3'(n % 8);
      i1.rdaddr = 3'((n + 1) % 8);
      i1.wrdata = 25'(n);
      tick();
      if (n >= 8) begin
        chk("stream_data", 32'(i1.rddata), 32'(n - 7));
        chk("stream_valid", 32'(i1.rdvalid), 32'h1);
      end
    end
    idle_all();

    // Output-register latency
    i2.wren = 1; i2.wraddr = 4'd0; i2.wrdata = 25'h5;
    tick();
    m2[0] = 25'h5;
    i2.wren = 0; i2.rden = 1; i2.rdaddr = 4'd0;
    tick();
    i2.rden = 0;
    chk("lat_edge1_valid", 32'(i2.rdvalid), 32'h0);
    tick();
    chk("lat_edge2_valid", 32'(i2.rdvalid), 32'h1);
    chk("lat_edge2_data", 32'(i2.rddata), 32'h5);
    tick();
    chk("lat_edge3_valid", 32'(i2.rdvalid), 32'h0);
    chk("lat_edge3_hold", 32'(i2.rddata), 32'h5);

    // Bounds on the 6-word RAM: fill, then try writes beyond the end
    for (int a = 0; a < 8; a++) begin
      i3.wren = 1; i3.wraddr = 3'(a); i3.wrdata = 25'(32'h100 + a);
      tick();
      if (a < 6) m3[a] = 25'(32'h100 + a);
    end
    i3.wren = 0;
    for (int a = 0; a < 8; a++) begin
      i3.rden = 1; i3.rdaddr = 3'(a);
      tick();
      chk("bounds_data", 32'(i3.rddata), (a < 6) ? 32'(m3[a]) : 32'h0);
      chk("bounds_valid", 32'(i3.rdvalid), 32'h1);
    end
    idle_all();
    tick();

    // Random traffic against the reference model
    p2v = 1'b0; p2d = '0;
    for (int k = 0; k < 400; k++) begin
      i0.rden = 1'($urandom_range(1)); i0.wren = 1'($urandom_range(1));
      a0r = $urandom_range(15); a0w = $urandom_range(15); d0 = 25'($urandom);
      i0.rdaddr = 9'(a0r); i0.wraddr = 9'(a0w); i0.wrdata = d0;
      i2.rden = 1'($urandom_range(1)); i2.wren = 1'($urandom_range(1));
      a2r = $urandom_range(15); a2w = $urandom_range(15); d2 = 25'($urandom);
      i2.rdaddr = 4'(a2r); i2.wraddr = 4'(a2w); i2.wrdata = d2;
      i3.rden = 1'($urandom_range(1)); i3.wren = 1'($urandom_range(1));
      a3r = $urandom_range(7); a3w = $urandom_range(7); d3 = 25'($urandom);
      i3.rdaddr = 3'(a3r); i3.wraddr = 3'(a3w); i3.wrdata = d3;

      // Reads see contents before this edge's write (read-old policy).
      e0 = m0[a0r]; v0 = i0.rden;
      e3 = (a3r < 6) ? m3[a3r] : '0; v3 = i3.rden;
      e2 = p2d; v2 = p2v;
      if (i2.rden) begin p2d = m2[a2r]; p2v = 1'b1; end else p2v = 1'b0;
      if (i0.wren) m0[a0w] = d0;
      if (i2.wren) m2[a2w] = d2;
      if (i3.wren && a3w < 6) m3[a3w] = d3;

      tick();
      chk("rnd_u0_valid", 32'(i0.rdvalid), 32'(v0));
      if (v0) chk("rnd_u0_data", 32'(i0.rddata), 32'(e0));
      chk("rnd_u2_valid", 32'(i2.rdvalid), 32'(v2));
      if (v2) chk("rnd_u2_data", 32'(i2.rddata), 32'(e2));
      chk("rnd_u3_valid", 32'(i3.rdvalid), 32'(v3));
      if (v3) chk("rnd_u3_data", 32'(i3.rddata), 32'(e3));
    end

    idle_all();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdp_ram.md
Name: sdp_ram

Overview:
- Simple dual-port synchronous RAM: one write port, one read port, sharing a single clock.
- Primary use is as the storage element behind RAM-based shift registers and delay lines in the FMCW gateware.
- The write port and read port may both be active every cycle.
- Infers block RAM; only the read-data path is resettable, the array contents are not.

Parameters:
- WIDTH, 25, data word width in bits (>=1).
- SIZE, 512, number of words (>=2; need not be a power of two).
- BYPASS, 0, same-address read-during-write policy: 0 = read returns old data, 1 = read returns the newly written data.
- OUT_REG, 0, 1 adds a pipeline register on rddata/rdvalid (read latency 2 instead of 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rden  in  1  read enable.
- rdaddr  in  AW  read address; AW = max(1, clog2(SIZE)).
- rddata  out  WIDTH  read data.
- rdvalid  out  1  high when rddata carries the result of an enabled read.
- wren  in  1  write enable.
- wraddr  in  AW  write address.
- wrdata  in  WIDTH  write data.

Behaviour:
- Reset:
  - rst is asynchronous: on assertion, rddata=0, rdvalid=0, and the OUT_REG stage is also cleared to 0.
  - The memory array is not cleared. Simulation initial contents are all zeros.
  - Reset mid-operation aborts in-flight reads; writes are ignored while rst=1.
- Write: at a clk edge with wren=1 and wraddr<SIZE, mem[wraddr] <= wrdata. If wraddr>=SIZE the write is dropped.
- Read, OUT_REG=0:
  - At a clk edge with rden=1, rddata <= mem[rdaddr] (latency 1) and rdvalid <= 1.
  - With rden=0, rddata holds its previous value and rdvalid <= 0.
- Read, OUT_REG=1: one additional register stage. rddata/rdvalid appear 2 edges after the rden edge; the output stage holds when its input is not valid.
- Out of range: rdaddr>=SIZE returns 0 (rdvalid still asserted).
- Same address, same edge (rden=wren=1, rdaddr==wraddr):
  - BYPASS=0: read returns the value stored before the write.
  - BYPASS=1: read returns wrdata.
  - In both cases the write completes.
- Different addresses on the same edge are fully independent.
- Address wrap is not the RAM's job; the caller wraps addresses itself.
- No combinational path from any input to rddata.

Decomposition:
- Shared package ram_pkg:
  - function addr_width(size) returning max(1, clog2(size));
  - localparams for the BYPASS encodings, RD_OLD=0 and RD_NEW=1.
- No sub-module. The array, read register, bypass mux and optional output stage fit in one module; the output stage is a generate block, not a separate module.

Test Plan:
- Reset: assert rst asynchronously between edges -> rddata=0 and rdvalid=0 immediately; after release, rden=0 keeps rdvalid=0.
- Basic write/read (OUT_REG=0): write 0x0ABCDEF at addr 5, then rden at addr 5 -> next edge rddata=0x0ABCDEF, rdvalid=1. Then rden=0 -> rddata holds 0x0ABCDEF, rdvalid=0.
- Collision, both modes, with mem[3]=0x11 beforehand: write 0x22 to addr 3 and read addr 3 on the same edge.
  - BYPASS=0 -> rddata=0x11; a subsequent read returns 0x22.
  - BYPASS=1 -> rddata=0x22.
- Streaming delay line, SIZE=8:
  - wraddr cycles 0..7, rdaddr=wraddr+1 mod 8, both enables high every cycle, wrdata=n.
  - Expect rddata=n-7 from cycle 8 onward, with no gaps.
- Latency, OUT_REG=1: single read of addr 0 holding 0x5 -> rdvalid and rddata=0x5 appear exactly 2 edges later.
- Bounds, SIZE=6: write to addr 7 is dropped (mem unchanged); read of addr 7 -> rddata=0.
